key_debounce: RTL
=================

// Module: key_debounce
// PURPOSE
//  Cleans a raw, bouncing, asynchronous push-button input into a stable level plus one-cycle press and release pulses.
//  Sits directly upstream of the system control stage: key_press/key_level drive that stage's data input ('a').
//  Single clock domain: clk. All state is reset synchronously by rst_n.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   cycles input must stay stable to accept a change (20 ms @ 50 MHz); legal >= 1
//  LONG_CYCLES      50_000_000  cycles of accepted hold before long_press (1 s @ 50 MHz); legal >= 1; used only with macro
//  KEY_ACTIVE_LOW   1           1: key_in==0 means pressed; 0: key_in==1 means pressed
// PORTS
//  clk          input   1  system clock; all flops on posedge
//  rst_n        input   1  reset, synchronous, active-low
//  key_in       input   1  raw button pin, asynchronous to clk, may bounce
//  key_level    output  1  debounced state, 1 = pressed
//  key_press    output  1  one-cycle pulse on accepted press
//  key_release  output  1  one-cycle pulse on accepted release
//  long_press   output  1  one-cycle pulse after LONG_CYCLES of hold (KEY_DEBOUNCE_LONG_EN only)
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE; counters=0; key_level/key_press/key_release/long_press=0.
//    Both sync flops load the INACTIVE pin level (1 if KEY_ACTIVE_LOW, else 0). Reset mid-debounce or mid-hold aborts it with no pulse.
//  - Sync: key_in -> sync1 -> sync2 (2 flops). pressed = KEY_ACTIVE_LOW ? ~sync2 : sync2. Only sync2 feeds the FSM.
//  - cnt: width $clog2(DEBOUNCE_CYCLES+1); cleared to 0 on every state transition.
//  - FSM (all outputs registered):
//    IDLE:         pressed -> PRESS_WAIT (cnt=0); else stay
//    PRESS_WAIT:   !pressed -> IDLE (bounce, no pulse)
//                  pressed & cnt==DEBOUNCE_CYCLES-1 -> PRESSED; key_press=1 and key_level=1 for that cycle onward
//                  else cnt++
//    PRESSED:      !pressed -> RELEASE_WAIT (cnt=0); key_level stays 1
//    RELEASE_WAIT: pressed -> PRESSED (bounce, no pulse, no second key_press)
//                  !pressed & cnt==DEBOUNCE_CYCLES-1 -> IDLE; key_release=1, key_level=0
//                  else cnt++
//  - Latency: pin becomes pressed and stays so; first posedge sampling it = E0. key_press and key_level
//    go high at edge E0+DEBOUNCE_CYCLES+2. Release is symmetric (key_release high, key_level low, at E0+DEBOUNCE_CYCLES+2).
//  - key_press and key_release are high for exactly one cycle and never in the same cycle.
//    A pulse shorter than DEBOUNCE_CYCLES stable cycles produces no output change.
//  - Pin already pressed at reset release -> treated as a new press; key_press after DEBOUNCE_CYCLES+2 edges.
// CONFIGURATION
//  KEY_DEBOUNCE_LONG_EN defined:
//    Adds hold_cnt, width $clog2(LONG_CYCLES+1). Cleared in IDLE and PRESS_WAIT.
//    Increments each cycle in PRESSED or RELEASE_WAIT; saturates at LONG_CYCLES.
//    long_press=1 for exactly one cycle when hold_cnt steps from LONG_CYCLES-1 to LONG_CYCLES.
//    At most one long_press per accepted press; release bounces neither reset nor restart hold_cnt.
//    Earliest long_press is LONG_CYCLES edges after key_press. long_press reset value 0.
//  KEY_DEBOUNCE_LONG_EN undefined:
//    long_press port and hold_cnt are absent; all other behaviour is identical.
// TESTING  (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, KEY_ACTIVE_LOW=1)
//  1 Clean press: key_in 1->0 sampled at E0, held -> key_press=1 only at E0+6; key_level=1 from E0+6.
//  2 Bounce reject: key_in low 3 cycles, then high -> key_level, key_press and key_release stay 0 throughout.
//  3 Release bounce: while pressed, key_in high 2 cycles then low again -> no key_release, no second key_press,
//    key_level stays 1.
//  4 Clean release: key_in 0->1 at E0, held -> key_release=1 only at E0+6; key_level=0 from E0+6.
//  5 Reset mid-op: rst_n=0 for 1 cycle during PRESS_WAIT (cnt=2) -> all outputs 0.
//    Key still held -> key_press at 6 edges after rst_n returns high.
//  6 [LONG_EN] Hold key 20 cycles after key_press -> single long_press exactly 10 edges after key_press;
//    undefined build: port absent, cases 1-5 unchanged.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus debounce FSM for a bouncing push-button.
// Produces a debounced level and one-cycle press/release pulses.
// Optional feature: define KEY_DEBOUNCE_LONG_EN to add the hold timer and the long_press output.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
`ifdef KEY_DEBOUNCE_LONG_EN
    ,
    output logic long_press
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic PIN_IDLE = KEY_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic             sync1;
    logic             sync2;
    logic             pressed;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;

    // Bring the asynchronous pin into the clk domain; reset to the released pin level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign pressed = KEY_ACTIVE_LOW ? ~sync2 : sync2;

    // State, stability counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

    // Next state: a change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = key_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef KEY_DEBOUNCE_LONG_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              long_d;

    // Hold timer register and registered long_press pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q     <= '0;
            long_press <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            long_press <= long_d;
        end
    end

    // Count accepted-hold cycles, saturating so long_press fires once per press.
    always_comb begin
        hold_d = '0;
        long_d = 1'b0;
        if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
            hold_d = hold_q;
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_W'(1);
                long_d = (hold_q == HOLD_LAST);
            end
        end
    end
`else
    // Hold timer absent in this build; LONG_CYCLES stays so both builds share one parameter list.
    if (LONG_CYCLES == 0) begin : g_long_cycles_unused
    end
`endif

endmodule
